// File: rtl/latch_bus_ctrl.sv
// latch_bus_ctrl: drives a shared bus A with per-channel LE/OE for a bank of latches through setup/pulse/hold writes and turnaround/sample readback (CLK, RST sync active-high; REQ_* request handshake; A/LE/OE to the latches; Y_IN readback bus; RSP_* one-cycle completion), readback present only with LATCH_BUS_READBACK_EN
module latch_bus_ctrl #(
  parameter int W = 8,
  parameter int N_CH = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC = 1,
  parameter int TURN_CYC = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WR,
  input  logic [$clog2(N_CH):0] REQ_CH,
  input  logic [W-1:0]          REQ_DATA,
  output logic [W-1:0]          A,
  output logic [N_CH-1:0]       LE,
  output logic [N_CH-1:0]       OE,
  input  logic [W-1:0]          Y_IN,
  output logic                  RSP_VALID,
  output logic [W-1:0]          RSP_DATA,
  output logic                  RSP_ERR
);
  localparam int CW = $clog2(N_CH) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD
`ifdef LATCH_BUS_READBACK_EN
    , TURN, SAMPLE
`endif
  } state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [CW-1:0] ch;
  logic [N_CH-1:0] sel;
  logic accept, err, done, cap;
  assign REQ_READY = state == IDLE;
  assign accept = REQ_VALID && REQ_READY;
  assign sel = N_CH'(1) << ch;
  assign LE = state == PULSE ? sel : '0;
`ifdef LATCH_BUS_READBACK_EN
  assign err = REQ_CH >= CW'(N_CH);
  assign OE = (state == TURN || state == SAMPLE) ? sel : '0;
`else
  assign err = REQ_CH >= CW'(N_CH) || !REQ_WR;
  assign OE = '0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt - 4'd1;
    done = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        done = accept && err;
        if (accept && !err) begin
`ifdef LATCH_BUS_READBACK_EN
          state_n = REQ_WR ? SETUP : TURN;
          cnt_n = REQ_WR ? 4'(SETUP_CYC - 1) : 4'(TURN_CYC - 1);
`else
          state_n = SETUP;
          cnt_n = 4'(SETUP_CYC - 1);
`endif
        end
      end
      SETUP: if (cnt == '0) begin
        state_n = PULSE;
        cnt_n = 4'(PULSE_CYC - 1);
      end
      PULSE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n = 4'(HOLD_CYC - 1);
      end
      HOLD: if (cnt == '0) begin
        state_n = IDLE;
        cnt_n = '0;
        done = 1'b1;
      end
`ifdef LATCH_BUS_READBACK_EN
      TURN: if (cnt == '0) begin
        state_n = SAMPLE;
        cnt_n = '0;
      end
      SAMPLE: begin
        state_n = IDLE;
        cnt_n = '0;
        done = 1'b1;
        cap = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      A <= '0;
      RSP_VALID <= 1'b0;
      RSP_ERR <= 1'b0;
      RSP_DATA <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      RSP_VALID <= done;
      RSP_ERR <= done && state == IDLE;
      if (accept) ch <= REQ_CH;
      if (accept && REQ_WR && !err) A <= REQ_DATA;
      if (cap) RSP_DATA <= Y_IN;
    end
  end
endmodule
